// File: rtl/y86_trace_capture_if.sv
// y86_trace_capture_if
//   Bundles the commit-side inputs and the serialized byte stream of the
//   y86 commit-trace capture block.
//   Signals:
//     commit_valid  one instruction retires this cycle
//     commit_pc     PC of the retiring instruction
//     wb_en         retiring instruction writes a register
//     wb_reg        destination register (0=eax ... 7=edi)
//     wb_data       value written
//     out_valid     out_data holds a valid frame byte
//     out_data      frame byte
//     out_ready     sink accepts the byte when out_valid && out_ready
//   Modports:
//     master  CPU commit point / byte sink side (drives commit, out_ready)
//     slave   trace capture block (drives out_valid, out_data)
interface y86_trace_capture_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [31:0] wb_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    modport master (
        output commit_valid, commit_pc, wb_en, wb_reg, wb_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  commit_valid, commit_pc, wb_en, wb_reg, wb_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/y86_trace_capture.sv
// y86_trace_capture
//   Commit-trace capture for the y86 CPU. Each retired instruction's PC and
//   register writeback are buffered in a circular FIFO and serialized as
//   10-byte frames on a valid/ready byte stream:
//     byte 0    SYNC_BYTE
//     bytes 1-4 pc, least significant byte first
//     byte 5    {wb_en, 4'b0000, wb_reg}
//     bytes 6-9 wb_data, least significant byte first
//   When the FIFO is full the newest record is dropped and counted.
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous, active-high
//     trace_en    capture enable; commits ignored while low
//     bus         commit inputs and output byte stream (slave modport)
//     fifo_count  records currently buffered
//     overflow    sticky: at least one record dropped
//     drop_count  records dropped, saturating at all-ones
//     busy        serializer is mid-frame
module y86_trace_capture #(
    parameter int          DEPTH     = 16,
    parameter int          CNT_W     = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    y86_trace_capture_if.slave       bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    // Record layout: {pc[67:36], wb_en[35], wb_reg[34:32], wb_data[31:0]}
    logic [67:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [67:0]   head;
    logic [67:0]   rec_in;
    logic [71:0]   shift_reg;
    logic [3:0]    byte_idx;
    state_t        state;

    logic capture;
    logic pop;
    logic push;
    logic drop;
    logic fire;

    always_comb begin
        capture = trace_en && bus.commit_valid;
        pop     = (state == IDLE) && (fifo_count != '0);
        // A full FIFO still accepts a commit when the serializer pops on the same edge.
        push    = capture && ((fifo_count != FULL) || pop);
        drop    = capture && !push;
        fire    = bus.out_valid && bus.out_ready;
        rec_in  = {bus.commit_pc, bus.wb_en, bus.wb_reg, bus.wb_data};
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            overflow      <= 1'b0;
            drop_count    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            shift_reg     <= '0;
            byte_idx      <= '0;
            busy          <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        // Bytes 1..9 packed LSB-first so each accepted byte is a plain shift.
                        shift_reg     <= {head[31:0], head[35], 4'b0000, head[34:32], head[67:36]};
                        rd_ptr        <= rd_ptr + 1'b1;
                        bus.out_data  <= SYNC_BYTE;
                        bus.out_valid <= 1'b1;
                        byte_idx      <= '0;
                        busy          <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (fire) begin
                        if (byte_idx == 4'd9) begin
                            bus.out_valid <= 1'b0;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            byte_idx     <= byte_idx + 1'b1;
                            bus.out_data <= shift_reg[7:0];
                            shift_reg    <= {8'h00, shift_reg[71:8]};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_y86_trace_capture.sv
module tb_y86_trace_capture;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        busy;

    y86_trace_capture_if bus();

    always #5 clk = ~clk;

    y86_trace_capture #(.DEPTH(16), .CNT_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .trace_en   (trace_en),
        .bus        (bus.slave),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of records plus frame being sent
    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [2:0]  rg;
        logic [31:0] d;
    } rec_t;

    rec_t        mq[$];
    rec_t        m_r;
    bit          m_send = 0;
    int          m_idx  = 0;
    logic [7:0]  m_frame[10];
    bit          m_ovf  = 0;
    int unsigned m_drop = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_send = 0;
            m_idx  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            if (m_send) begin
                if (bus.out_ready) begin
                    m_idx++;
                    if (m_idx == 10) m_send = 0;
                end
            end else if (mq.size() != 0) begin
                m_r = mq.pop_front();
                m_frame[0] = 8'hA5;
                m_frame[1] = m_r.pc[7:0];
                m_frame[2] = m_r.pc[15:8];
                m_frame[3] = m_r.pc[23:16];
                m_frame[4] = m_r.pc[31:24];
                m_frame[5] = {m_r.en, 4'b0000, m_r.rg};
                m_frame[6] = m_r.d[7:0];
                m_frame[7] = m_r.d[15:8];
                m_frame[8] = m_r.d[23:16];
                m_frame[9] = m_r.d[31:24];
                m_idx  = 0;
                m_send = 1;
            end
            if (trace_en && bus.commit_valid) begin
                // size is already post-pop, so a same-edge pop frees a slot
                if (mq.size() < DEPTH)
                    mq.push_back(rec_t'{bus.commit_pc, bus.wb_en, bus.wb_reg, bus.wb_data});
                else begin
                    m_ovf = 1;
                    if (m_drop != 32'hFFFF) m_drop++;
                end
            end
        end
        #1;
        chk("m_out_valid",  80'(bus.out_valid), 80'(m_send));
        chk("m_busy",       80'(busy),          80'(m_send));
        chk("m_fifo_count", 80'(fifo_count),    80'(mq.size()));
        chk("m_overflow",   80'(overflow),      80'(m_ovf));
        chk("m_drop_count", 80'(drop_count),    80'(m_drop));
        if (m_send) chk("m_out_data", 80'(bus.out_data), 80'(m_frame[m_idx]));
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic en, input logic [2:0] rg,
                          input logic [31:0] d);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        bus.wb_en        = en;
        bus.wb_reg       = rg;
        bus.wb_data      = d;
        step();
        bus.commit_valid = 1'b0;
    endtask

    task automatic recv_frame(input bit bp, output logic [79:0] got);
        int n   = 0;
        int cyc = 0;
        got = '0;
        while (n < 10 && cyc < 200) begin
            bus.out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                got[79-8*n -: 8] = bus.out_data;
                n++;
            end
            step();
            cyc++;
        end
        if (n < 10) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout got=%0d bytes required=10", n);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [2:0]  rg;
        logic [31:0] d;
        bit          bp;
        logic [79:0] exp;
    } vec_t;

    vec_t        vecs[5];
    logic [79:0] got;
    logic [31:0] gpc;
    int          thr[3];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 80'hA5_00_01_00_00_83_EF_BE_AD_DE};
        vecs[1] = '{32'h0000_0100, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b1, 80'hA5_00_01_00_00_83_EF_BE_AD_DE};
        vecs[2] = '{32'h1234_5678, 1'b0, 3'd5, 32'h0000_00FF, 1'b0, 80'hA5_78_56_34_12_05_FF_00_00_00};
        vecs[3] = '{32'hFFFF_FFFC, 1'b1, 3'd7, 32'h8000_0001, 1'b1, 80'hA5_FC_FF_FF_FF_87_01_00_00_80};
        vecs[4] = '{32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 80'hA5_00_00_00_00_00_00_00_00_00};

        reset            = 1'b1;
        trace_en         = 1'b1;
        bus.commit_valid = 1'b0;
        bus.commit_pc    = '0;
        bus.wb_en        = 1'b0;
        bus.wb_reg       = '0;
        bus.wb_data      = '0;
        bus.out_ready    = 1'b0;
        step();
        step();
        chk("rst_out_valid",  80'(bus.out_valid), 80'd0);
        chk("rst_fifo_count", 80'(fifo_count),    80'd0);
        chk("rst_overflow",   80'(overflow),      80'd0);
        chk("rst_drop_count", 80'(drop_count),    80'd0);
        chk("rst_busy",       80'(busy),          80'd0);
        reset = 1'b0;
        step();

        // single frames, with and without 1010 backpressure
        foreach (vecs[i]) begin
            bus.out_ready = 1'b0;
            commit(vecs[i].pc, vecs[i].en, vecs[i].rg, vecs[i].d);
            chk("lat_edge_n",  80'(bus.out_valid), 80'd0);
            step();
            chk("lat_edge_n1", 80'(bus.out_valid), 80'd1);
            recv_frame(vecs[i].bp, got);
            chk("frame_vec", got, vecs[i].exp);
            bus.out_ready = 1'b0;
            repeat (2) step();
        end

        // trace_en low: commits ignored
        trace_en = 1'b0;
        for (int i = 0; i < 5; i++) commit(32'h4000 + 32'(i), 1'b1, 3'd1, 32'(i));
        chk("dis_fifo_count", 80'(fifo_count),    80'd0);
        chk("dis_drop_count", 80'(drop_count),    80'd0);
        chk("dis_out_valid",  80'(bus.out_valid), 80'd0);
        trace_en = 1'b1;

        // overflow: serializer parked mid-frame, then 20 commits
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        commit(32'hAAAA_0000, 1'b0, 3'd0, 32'h0);
        for (int b = 0; b < 10 && !busy; b++) step();
        chk("ovf_pre_busy", 80'(busy), 80'd1);
        for (int i = 0; i < 20; i++)
            commit(32'h1000 + 32'(4 * i), 1'(i % 2), 3'(i), $urandom);
        chk("ovf_fifo_count", 80'(fifo_count), 80'd16);
        chk("ovf_overflow",   80'(overflow),   80'd1);
        chk("ovf_drop_count", 80'(drop_count), 80'd4);

        // full plus simultaneous pop: finish the parked frame, commit on the pop edge
        bus.out_ready = 1'b1;
        for (int b = 0; b < 50 && busy; b++) step();
        chk("full_idle_busy",  80'(busy),       80'd0);
        chk("full_idle_count", 80'(fifo_count), 80'd16);
        commit(32'hBBBB_0000, 1'b1, 3'd6, 32'h1234_5678);
        chk("full_pop_count", 80'(fifo_count), 80'd16);
        chk("full_pop_drop",  80'(drop_count), 80'd4);
        chk("full_pop_busy",  80'(busy),       80'd1);
        for (int k = 0; k < 17; k++) begin
            recv_frame(1'b0, got);
            gpc = {got[47:40], got[55:48], got[63:56], got[71:64]};
            chk("drain_pc", 80'(gpc), (k < 16) ? 80'(32'h1000 + 32'(4 * k)) : 80'(32'hBBBB_0000));
        end

        // reset at frame byte 4 (overflow still set from above)
        commit(32'hC0DE_0000, 1'b1, 3'd1, 32'h5555_AAAA);
        bus.out_ready = 1'b1;
        begin
            int n = 0;
            for (int c = 0; c < 40 && n < 4; c++) begin
                if (bus.out_valid && bus.out_ready) n++;
                step();
            end
            chk("abort_bytes_sent", 80'(n), 80'd4);
        end
        chk("abort_pre_busy", 80'(busy),     80'd1);
        chk("abort_pre_ovf",  80'(overflow), 80'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_out_valid",  80'(bus.out_valid), 80'd0);
        chk("abort_fifo_count", 80'(fifo_count),    80'd0);
        chk("abort_overflow",   80'(overflow),      80'd0);
        commit(32'h00C0_FFEE, 1'b1, 3'd2, 32'h0102_0304);
        recv_frame(1'b0, got);
        chk("abort_next_frame", got, 80'hA5_EE_FF_C0_00_82_04_03_02_01);

        // randomized traffic against the model, light to heavy backpressure
        thr[0] = 100;
        thr[1] = 30;
        thr[2] = 5;
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 300; c++) begin
                bus.commit_valid = 1'($urandom_range(0, 1));
                trace_en         = ($urandom_range(0, 9) != 0);
                bus.commit_pc    = $urandom;
                bus.wb_en        = 1'($urandom_range(0, 1));
                bus.wb_reg       = 3'($urandom_range(0, 7));
                bus.wb_data      = $urandom;
                bus.out_ready    = ($urandom_range(0, 99) < thr[ph]);
                step();
            end
        end
        bus.commit_valid = 1'b0;
        trace_en         = 1'b0;
        bus.out_ready    = 1'b1;
        repeat (250) step();
        chk("final_fifo_empty", 80'(fifo_count), 80'd0);
        chk("final_idle",       80'(busy),       80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
